// File: rtl/nv_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nv_ram_pkg
//  Description : Shared helpers for the parametrised read/write-split RAM:
//                address-width calculation, read-latency constants and the
//                lane-merge function used by both storage write and bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
package nv_ram_pkg;

    // Widest word / most lanes the generic merge helper can handle.
    localparam int c_nv_max_width   = 1024;
    localparam int c_nv_max_lanes   = 1024;

    // Array read plus the stage-0 register gives one cycle of latency.
    localparam int c_nv_base_rd_lat = 1;

    // Address width for a given depth; at least one bit even for tiny arrays.
    function automatic int nv_clog2(input int i_n);
        int r;
        r = 1;
        for (int b = 1; b < 31; b++) begin
            if ((1 << b) < i_n) begin
                r = b + 1;
            end
        end
        return r;
    endfunction

    // Read latency seen at the output pins for a given output-register choice.
    function automatic int nv_rd_lat(input int i_out_reg);
        return c_nv_base_rd_lat + ((i_out_reg != 0) ? 1 : 0);
    endfunction

    // Lane-wise merge: lanes whose mask bit is set take the new word, the rest
    // keep the old word. Callers zero-extend their operands and keep only the
    // low WIDTH bits of the result.
    function automatic logic [c_nv_max_width-1:0] nv_lane_merge(
        input logic [c_nv_max_width-1:0] i_old,
        input logic [c_nv_max_width-1:0] i_new,
        input logic [c_nv_max_lanes-1:0] i_mask,
        input int                        i_gran
    );
        logic [c_nv_max_width-1:0] merged;
        merged = i_old;
        for (int i = 0; i < c_nv_max_width; i++) begin
            if (i_mask[i / i_gran]) begin
                merged[i] = i_new[i];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nv_ram_rws_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : nv_ram_rws_param_if
//  Description : Bus bundle for the read/write-split RAM. The master drives
//                both address ports and write data; the slave (the RAM)
//                returns read data, valid, collision and address-error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nv_ram_rws_param_if
    import nv_ram_pkg::*;
#(
    parameter int AW    = nv_clog2(256),
    parameter int WIDTH = 64,
    parameter int LANES = 8
);
    logic [AW-1:0]    ra;
    logic             re;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW-1:0]    wa;
    logic             we;
    logic [LANES-1:0] wmask;
    logic [WIDTH-1:0] di;
    logic             collision;
    logic             addr_err;
    logic [31:0]      pwrbus_ram_pd;

    modport master (
        output ra, re, wa, we, wmask, di, pwrbus_ram_pd,
        input  dout, dout_vld, collision, addr_err
    );

    modport slave (
        input  ra, re, wa, we, wmask, di, pwrbus_ram_pd,
        output dout, dout_vld, collision, addr_err
    );

endinterface
`default_nettype wire

// File: rtl/nv_ram_rws_param_core.sv
`default_nettype none
// ============================================================================
//  Module      : nv_ram_rws_param_core
//  Description : Bare storage array: masked write port, registered read
//                address. No reset, so a hard macro can replace it one-for-one.
//                Also exposes the current word at the write address so the
//                wrapper can resolve collisions without a second read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module nv_ram_rws_param_core
    import nv_ram_pkg::*;
#(
    parameter  int WIDTH     = 64,
    parameter  int DEPTH     = 256,
    parameter  int MASK_GRAN = 8,
    localparam int c_aw      = nv_clog2(DEPTH),
    localparam int c_lanes   = WIDTH / MASK_GRAN
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [c_aw-1:0]    i_wa,
    input  logic [c_lanes-1:0] i_wmask,
    input  logic [WIDTH-1:0]   i_di,
    input  logic               i_re,
    input  logic [c_aw-1:0]    i_ra,
    output logic [WIDTH-1:0]   o_rdata,
    output logic [WIDTH-1:0]   o_wold
);

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [c_aw-1:0]           r_ra;
    logic [c_nv_max_width-1:0] w_wdata_wide;
    logic [WIDTH-1:0]          w_wdata;
    logic                      w_unused_wdata;

    // Pre-write contents at the write address feed the lane merge.
    assign o_wold = r_mem[i_wa];

    assign w_wdata_wide   = nv_lane_merge(c_nv_max_width'(o_wold),
                                          c_nv_max_width'(i_di),
                                          c_nv_max_lanes'(i_wmask),
                                          MASK_GRAN);
    assign w_wdata        = w_wdata_wide[WIDTH-1:0];
    assign w_unused_wdata = ^w_wdata_wide;

    // Masked write: unselected lanes are rewritten with their old value.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wa] <= w_wdata;
        end
    end

    // Read address is held between reads so the array output is stable.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_ra <= i_ra;
        end
    end

    assign o_rdata = r_mem[r_ra];

endmodule
`default_nettype wire

// File: rtl/nv_ram_rws_param.sv
`default_nettype none
// ============================================================================
//  Module      : nv_ram_rws_param
//  Description : Parametrised one-write/one-read RAM wrapper. Adds range
//                checking, deterministic same-address collision handling
//                (bypass or old-data), read-valid tracking, an optional output
//                register and an address-error pulse around the storage core.
//  Revision    : 1.0 - initial release
// ============================================================================
module nv_ram_rws_param
    import nv_ram_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 256,
    parameter int MASK_GRAN = 8,
    parameter int OUT_REG   = 0,
    parameter int BYPASS    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    nv_ram_rws_param_if.slave bus
);

    localparam int              c_aw     = nv_clog2(DEPTH);
    localparam int              c_rd_lat = nv_rd_lat(OUT_REG);
    localparam logic [c_aw:0]   c_depth  = (c_aw + 1)'(DEPTH);

    logic                      w_ra_bad;
    logic                      w_wa_bad;
    logic                      w_coll;
    logic [WIDTH-1:0]          w_rdata;
    logic [WIDTH-1:0]          w_wold;
    logic [c_nv_max_width-1:0] w_merge_wide;
    logic [WIDTH-1:0]          w_merged;
    logic [WIDTH-1:0]          w_s0_data;
    logic                      w_unused_merge;
    logic                      w_unused_pwr;

    // Read stage 0: address lives in the core, the rest is held here.
    logic                      r_s0_vld;
    logic                      r_s0_coll;
    logic                      r_s0_err;
    logic [WIDTH-1:0]          r_s0_bdata;
    logic                      r_addr_err;

    // The power-down bus is carried for pin compatibility only.
    assign w_unused_pwr = ^bus.pwrbus_ram_pd;

    // Addresses are checked, never wrapped.
    assign w_ra_bad = {1'b0, bus.ra} >= c_depth;
    assign w_wa_bad = {1'b0, bus.wa} >= c_depth;
    assign w_coll   = bus.re & bus.we & (bus.ra == bus.wa) & ~w_ra_bad;

    nv_ram_rws_param_core #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .MASK_GRAN (MASK_GRAN)
    ) u_core (
        .clk     (clk),
        .i_we    (bus.we & ~w_wa_bad),
        .i_wa    (bus.wa),
        .i_wmask (bus.wmask),
        .i_di    (bus.di),
        .i_re    (bus.re & ~w_ra_bad),
        .i_ra    (bus.ra),
        .o_rdata (w_rdata),
        .o_wold  (w_wold)
    );

    // Word the array will hold after this edge's write, used for bypass.
    assign w_merge_wide   = nv_lane_merge(c_nv_max_width'(w_wold),
                                          c_nv_max_width'(bus.di),
                                          c_nv_max_lanes'(bus.wmask),
                                          MASK_GRAN);
    assign w_merged       = w_merge_wide[WIDTH-1:0];
    assign w_unused_merge = ^w_merge_wide;

    // Capture read request, collision word and address error at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s0_vld   <= 1'b0;
            r_s0_coll  <= 1'b0;
            r_s0_err   <= 1'b0;
            r_s0_bdata <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_s0_vld   <= bus.re;
            r_s0_coll  <= w_coll;
            r_s0_err   <= bus.re & w_ra_bad;
            r_addr_err <= (bus.re & w_ra_bad) | (bus.we & w_wa_bad);
            if (w_coll) begin
                r_s0_bdata <= (BYPASS != 0) ? w_merged : w_wold;
            end
        end
    end

    // After a collision the array already holds the new word, so the word
    // chosen at the edge is used instead of the live array output.
    assign w_s0_data = r_s0_err  ? '0         :
                       r_s0_coll ? r_s0_bdata : w_rdata;

    assign bus.addr_err = r_addr_err;

    generate
        if (c_rd_lat > c_nv_base_rd_lat) begin : g_out_reg
            logic             r_s1_vld;
            logic             r_s1_coll;
            logic [WIDTH-1:0] r_s1_data;

            // Output register; data only moves on a valid read, so it holds.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_s1_vld  <= 1'b0;
                    r_s1_coll <= 1'b0;
                    r_s1_data <= '0;
                end else begin
                    r_s1_vld  <= r_s0_vld;
                    r_s1_coll <= r_s0_vld & r_s0_coll;
                    if (r_s0_vld) begin
                        r_s1_data <= w_s0_data;
                    end
                end
            end

            assign bus.dout      = r_s1_data;
            assign bus.dout_vld  = r_s1_vld;
            assign bus.collision = r_s1_coll;
        end else begin : g_out_comb
            logic [WIDTH-1:0] r_hold;

            // Keeps the last delivered word once the valid cycle has passed.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_hold <= '0;
                end else if (r_s0_vld) begin
                    r_hold <= w_s0_data;
                end
            end

            assign bus.dout      = r_s0_vld ? w_s0_data : r_hold;
            assign bus.dout_vld  = r_s0_vld;
            assign bus.collision = r_s0_vld & r_s0_coll;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_nv_ram_rws_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nv_ram_rws_param
//  Description : Directed bench for two builds of the RAM wrapper:
//                A = defaults (DEPTH 256, latency 1, bypass),
//                B = DEPTH 200, output register, old-data collisions.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nv_ram_rws_param;

    typedef struct {
        logic [63:0] data;
        logic        coll;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    int          cyc     = 0;
    int          n_total = 0;
    int          n_pass  = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [63:0] m_a [256];
    logic [63:0] m_b [256];

    nv_ram_rws_param_if #(.AW(8), .WIDTH(64), .LANES(8)) if_a ();
    nv_ram_rws_param_if #(.AW(8), .WIDTH(64), .LANES(8)) if_b ();

    nv_ram_rws_param #(
        .WIDTH(64), .DEPTH(256), .MASK_GRAN(8), .OUT_REG(0), .BYPASS(1)
    ) u_dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_a)
    );

    nv_ram_rws_param #(
        .WIDTH(64), .DEPTH(200), .MASK_GRAN(8), .OUT_REG(1), .BYPASS(0)
    ) u_dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one cycle of stimulus to build d, updates the reference
    // memory and queues the expected read result.
    task automatic drive(input bit d, input bit we, input logic [7:0] wa,
                         input logic [63:0] di, input logic [7:0] wm,
                         input bit re, input logic [7:0] ra);
        logic [63:0] old_w;
        logic [63:0] mrg;
        exp_t        e;
        bit          rbad;
        bit          wbad;
        bit          coll;
        int          depth;
        depth = d ? 200 : 256;
        rbad  = int'(ra) >= depth;
        wbad  = int'(wa) >= depth;
        old_w = d ? m_b[wa] : m_a[wa];
        for (int l = 0; l < 8; l++) begin
            mrg[l*8 +: 8] = wm[l] ? di[l*8 +: 8] : old_w[l*8 +: 8];
        end
        coll = re && we && (ra == wa) && !rbad;
        if (re) begin
            if (rbad)      e.data = 64'd0;
            else if (coll) e.data = d ? old_w : mrg;
            else           e.data = d ? m_b[ra] : m_a[ra];
            e.coll = coll;
            e.due  = cyc + (d ? 2 : 1);
            if (d) q_b.push_back(e);
            else   q_a.push_back(e);
        end
        if (we && !wbad) begin
            if (d) m_b[wa] = mrg;
            else   m_a[wa] = mrg;
        end
        if (d) begin
            if_b.we = we; if_b.wa = wa; if_b.di = di; if_b.wmask = wm;
            if_b.re = re; if_b.ra = ra;
        end else begin
            if_a.we = we; if_a.wa = wa; if_a.di = di; if_a.wmask = wm;
            if_a.re = re; if_a.ra = ra;
        end
        tick(1);
    endtask

    task automatic idle(input bit d, input int n);
        if (d) begin if_b.we = 1'b0; if_b.re = 1'b0; end
        else   begin if_a.we = 1'b0; if_a.re = 1'b0; end
        tick(n);
    endtask

    // Scoreboard pop/compare for one build.
    task automatic mon(input bit d, input logic vld, input logic coll, input logic [63:0] dout);
        exp_t e;
        int   n;
        n = d ? q_b.size() : q_a.size();
        if (n > 0) begin
            e = d ? q_b[0] : q_a[0];
            if (e.due < cyc) begin
                chk(d ? "b_rd_late" : "a_rd_late", 64'(cyc), 64'(e.due));
                if (d) void'(q_b.pop_front());
                else   void'(q_a.pop_front());
                n--;
            end
        end
        if (vld) begin
            if (n == 0) begin
                chk(d ? "b_unexpected_vld" : "a_unexpected_vld", 64'(vld), 64'd0);
            end else begin
                if (d) e = q_b.pop_front();
                else   e = q_a.pop_front();
                chk(d ? "b_dout" : "a_dout", dout, e.data);
                chk(d ? "b_collision" : "a_collision", 64'(coll), 64'(e.coll));
                chk(d ? "b_latency" : "a_latency", 64'(cyc), 64'(e.due));
            end
        end else if (coll) begin
            chk(d ? "b_stray_coll" : "a_stray_coll", 64'(coll), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            mon(1'b0, if_a.dout_vld, if_a.collision, if_a.dout);
            mon(1'b1, if_b.dout_vld, if_b.collision, if_b.dout);
        end
    end

    initial begin
        rstn = 1'b0;
        if_a.we = 1'b0; if_a.re = 1'b0; if_a.wa = '0; if_a.ra = '0;
        if_a.di = '0;   if_a.wmask = '0; if_a.pwrbus_ram_pd = 32'd0;
        if_b.we = 1'b0; if_b.re = 1'b0; if_b.wa = '0; if_b.ra = '0;
        if_b.di = '0;   if_b.wmask = '0; if_b.pwrbus_ram_pd = 32'hDEAD_BEEF;
        tick(3);
        chk("a_rst_dout",      if_a.dout,              64'd0);
        chk("a_rst_vld",       64'(if_a.dout_vld),     64'd0);
        chk("a_rst_coll",      64'(if_a.collision),    64'd0);
        chk("a_rst_addr_err",  64'(if_a.addr_err),     64'd0);
        chk("b_rst_dout",      if_b.dout,              64'd0);
        chk("b_rst_vld",       64'(if_b.dout_vld),     64'd0);
        chk("b_rst_coll",      64'(if_b.collision),    64'd0);
        chk("b_rst_addr_err",  64'(if_b.addr_err),     64'd0);
        rstn = 1'b1;
        tick(2);

        // Build A: basic write then read
        drive(0, 1, 8'd5, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 8'd0);
        drive(0, 0, 8'd0, 64'd0, 8'h00, 1, 8'd5);
        idle(0, 2);
        chk("a_hold_dout", if_a.dout, 64'h0123_4567_89AB_CDEF);
        chk("a_hold_vld",  64'(if_a.dout_vld), 64'd0);

        // Build A: masked write over all-ones
        drive(0, 1, 8'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 8'd0);
        drive(0, 1, 8'd5, 64'd0, 8'h0F, 0, 8'd0);
        drive(0, 0, 8'd0, 64'd0, 8'h00, 1, 8'd5);
        idle(0, 2);
        chk("a_masked_word", if_a.dout, 64'hFFFF_FFFF_0000_0000);

        // Build A: full and partial collisions with bypass
        drive(0, 1, 8'd9, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, 8'd0);
        drive(0, 1, 8'd9, 64'h5555_5555_5555_5555, 8'hFF, 1, 8'd9);
        drive(0, 0, 8'd0, 64'd0, 8'h00, 1, 8'd9);
        drive(0, 1, 8'd9, 64'h1111_1111_1111_1111, 8'h3C, 1, 8'd9);
        drive(0, 0, 8'd0, 64'd0, 8'h00, 1, 8'd9);
        idle(0, 2);
        chk("a_partial_coll_word", if_a.dout, 64'h5555_1111_1111_5555);

        // Build A: independent ports, top address, zero-mask write
        drive(0, 1, 8'd10, 64'hCAFE_F00D_1234_5678, 8'hFF, 1, 8'd5);
        drive(0, 1, 8'd255, 64'h0F1E_2D3C_4B5A_6978, 8'hFF, 1, 8'd10);
        drive(0, 1, 8'd255, 64'd0, 8'h00, 1, 8'd255);
        drive(0, 0, 8'd0, 64'd0, 8'h00, 1, 8'd255);
        idle(0, 3);

        // Build B: collisions return pre-write contents
        drive(1, 1, 8'd9, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, 8'd0);
        drive(1, 1, 8'd9, 64'h5555_5555_5555_5555, 8'hFF, 1, 8'd9);
        drive(1, 0, 8'd0, 64'd0, 8'h00, 1, 8'd9);
        drive(1, 1, 8'd9, 64'h0F0F_0F0F_0F0F_0F0F, 8'hA5, 1, 8'd9);
        drive(1, 0, 8'd0, 64'd0, 8'h00, 1, 8'd9);
        idle(1, 3);

        // Build B: streaming reads, two-cycle latency
        for (int i = 0; i < 4; i++) drive(1, 1, 8'(i), 64'(10 + i), 8'hFF, 0, 8'd0);
        for (int i = 0; i < 4; i++) drive(1, 0, 8'd0, 64'd0, 8'h00, 1, 8'(i));
        idle(1, 4);
        chk("b_hold_dout", if_b.dout, 64'd13);
        chk("b_hold_vld",  64'(if_b.dout_vld), 64'd0);

        // Build B: out-of-range on both ports gives one error pulse
        drive(1, 1, 8'd200, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 1, 8'd250);
        chk("b_addr_err_pulse", 64'(if_b.addr_err), 64'd1);
        idle(1, 1);
        chk("b_addr_err_single", 64'(if_b.addr_err), 64'd0);
        drive(1, 0, 8'd0, 64'd0, 8'h00, 1, 8'd200);
        chk("b_addr_err_read", 64'(if_b.addr_err), 64'd1);
        drive(1, 1, 8'd199, 64'h1990_1990_1990_1990, 8'hFF, 0, 8'd0);
        chk("b_addr_err_clear", 64'(if_b.addr_err), 64'd0);
        drive(1, 0, 8'd0, 64'd0, 8'h00, 1, 8'd199);
        idle(1, 4);

        // Build B: reset one cycle after a read discards it
        drive(1, 0, 8'd0, 64'd0, 8'h00, 1, 8'd3);
        if_b.re = 1'b0;
        rstn = 1'b0;
        #1;
        chk("b_midrst_dout", if_b.dout, 64'd0);
        chk("b_midrst_vld",  64'(if_b.dout_vld), 64'd0);
        q_a.delete();
        q_b.delete();
        tick(2);
        rstn = 1'b1;
        idle(1, 5);
        drive(1, 0, 8'd0, 64'd0, 8'h00, 1, 8'd3);
        idle(1, 1);

        for (int k = 0; k < 10 && (q_a.size() + q_b.size()) > 0; k++) tick(1);
        chk("queues_drained", 64'(q_a.size() + q_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
